// File: rtl/rx_buffer.sv
// rx_buffer: serial-in/parallel-out receive buffer.
// Bits arrive LSB first, one per write strobe, and are shifted into a
// WIDTH-bit register. A completed word is held until a parallel read takes
// it. Bits that arrive while a word is waiting are dropped and flag overrun.
module rx_buffer #(
   parameter int WORD_SIZE = 8,
   parameter int NO_OF_WORDS = 1,
   localparam int WIDTH = WORD_SIZE * NO_OF_WORDS,
   // floor(log2(WIDTH)) + 2, matching the transmit buffer's counter
   localparam int COUNTER_WIDTH = $clog2(WIDTH + 1) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     data_serial_in,
   input  logic                     data_serial_wr_enable,
   input  logic                     data_parallel_rd_enable,
   output logic [WIDTH-1:0]         data_parallel_out,
   output logic                     data_parallel_valid,
   output logic                     full,
   output logic                     overrun,
   output logic [COUNTER_WIDTH-1:0] bit_count
);

   logic [WIDTH-1:0]         shreg_reg;
   logic [WIDTH-1:0]         shift_next;
   logic [WIDTH-1:0]         out_reg;
   logic                     valid_reg;
   logic                     overrun_reg;
   logic [COUNTER_WIDTH-1:0] count_reg;
   logic                     full_int;
   logic                     read_ok;

   // New bits enter at the MSB so the first bit lands at bit 0 after WIDTH
   // shifts. The cast form also works when WIDTH is 1.
   assign shift_next = WIDTH'({data_serial_in, shreg_reg} >> 1);

   assign full_int = (count_reg == COUNTER_WIDTH'(WIDTH));
   assign read_ok  = data_parallel_rd_enable && full_int;

   // Shift, count, read hand-off and overrun tracking with reset > read > write priority
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_reg   <= '0;
         count_reg   <= '0;
         out_reg     <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (read_ok) begin
            out_reg     <= shreg_reg;
            valid_reg   <= 1'b1;
            overrun_reg <= 1'b0;
            // A bit arriving on the read edge becomes bit one of the next word
            if (data_serial_wr_enable) begin
               shreg_reg <= shift_next;
               count_reg <= COUNTER_WIDTH'(1);
            end else begin
               count_reg <= '0;
            end
         end else if (data_serial_wr_enable && !full_int) begin
            shreg_reg <= shift_next;
            count_reg <= count_reg + COUNTER_WIDTH'(1);
         end else if (data_serial_wr_enable) begin
            // Word still unread: drop the bit and remember that it was lost
            overrun_reg <= 1'b1;
         end
      end
   end

   assign data_parallel_out   = out_reg;
   assign data_parallel_valid = valid_reg;
   assign full                = full_int;
   assign overrun             = overrun_reg;
   assign bit_count           = count_reg;

endmodule

// File: tb/tb_rx_buffer.sv
// Testbench for rx_buffer: an 8-bit instance and a 2x8-bit instance.
// Expected words are queued when a read is issued and compared when the
// design pulses data_parallel_valid.
module tb_rx_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        d8 = 1'b0, w8 = 1'b0, r8 = 1'b0;
   logic [7:0]  out8;
   logic        valid8, full8, ovr8;
   logic [4:0]  cnt8;

   logic        d16 = 1'b0, w16 = 1'b0, r16 = 1'b0;
   logic [15:0] out16;
   logic        valid16, full16, ovr16;
   logic [5:0]  cnt16;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp8[$];
   logic [31:0] exp16[$];

   always #5 clk = ~clk;

   rx_buffer #(.WORD_SIZE(8), .NO_OF_WORDS(1)) dut8 (
      .clk(clk), .reset(reset),
      .data_serial_in(d8), .data_serial_wr_enable(w8),
      .data_parallel_rd_enable(r8),
      .data_parallel_out(out8), .data_parallel_valid(valid8),
      .full(full8), .overrun(ovr8), .bit_count(cnt8)
   );

   rx_buffer #(.WORD_SIZE(8), .NO_OF_WORDS(2)) dut16 (
      .clk(clk), .reset(reset),
      .data_serial_in(d16), .data_serial_wr_enable(w16),
      .data_parallel_rd_enable(r16),
      .data_parallel_out(out16), .data_parallel_valid(valid16),
      .full(full16), .overrun(ovr16), .bit_count(cnt16)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, actual);
      end
   endtask

   // Outputs are sampled one time unit after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr8(input logic b);
      d8 = b; w8 = 1'b1;
      tick();
      w8 = 1'b0; d8 = 1'b0;
   endtask

   task automatic fill8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) wr8(v[i]);
   endtask

   task automatic read8(input logic [7:0] v);
      exp8.push_back(32'(v));
      r8 = 1'b1;
      tick();
      r8 = 1'b0;
   endtask

   // Scoreboard for the 8-bit instance
   always @(negedge clk) begin
      if (valid8) begin
         check("valid8_expected", 32'(exp8.size() != 0), 32'd1);
         if (exp8.size() != 0) check("data8", 32'(out8), exp8.pop_front());
      end
   end

   // Scoreboard for the 16-bit instance
   always @(negedge clk) begin
      if (valid16) begin
         check("valid16_expected", 32'(exp16.size() != 0), 32'd1);
         if (exp16.size() != 0) check("data16", 32'(out16), exp16.pop_front());
      end
   end

   initial begin
      logic [7:0]  prev;
      logic [7:0]  next;
      logic [15:0] w;

      // Reset with random inputs on both instances
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         d8 = 1'($urandom); w8 = 1'($urandom); r8 = 1'($urandom);
         d16 = 1'($urandom); w16 = 1'($urandom); r16 = 1'($urandom);
         tick();
      end
      check("rst_out8", 32'(out8), 32'd0);
      check("rst_valid8", 32'(valid8), 32'd0);
      check("rst_full8", 32'(full8), 32'd0);
      check("rst_ovr8", 32'(ovr8), 32'd0);
      check("rst_cnt8", 32'(cnt8), 32'd0);
      check("rst_out16", 32'(out16), 32'd0);
      check("rst_cnt16", 32'(cnt16), 32'd0);
      reset = 1'b0;
      d8 = 0; w8 = 0; r8 = 0; d16 = 0; w16 = 0; r16 = 0;
      tick();

      // Single word 0xA5
      for (int i = 0; i < 8; i++) begin
         wr8(8'hA5 >> i);
         check("a5_cnt", 32'(cnt8), 32'(i + 1));
         check("a5_full", 32'(full8), 32'(i == 7));
      end
      read8(8'hA5);
      check("a5_valid", 32'(valid8), 32'd1);
      check("a5_full_after", 32'(full8), 32'd0);
      check("a5_cnt_after", 32'(cnt8), 32'd0);
      tick();
      check("a5_valid_pulse", 32'(valid8), 32'd0);
      check("a5_hold", 32'(out8), 32'hA5);

      // Overrun
      fill8(8'h3C);
      check("ovr_before", 32'(ovr8), 32'd0);
      wr8(1'b1);
      check("ovr_first", 32'(ovr8), 32'd1);
      wr8(1'b1);
      check("ovr_second", 32'(ovr8), 32'd1);
      check("ovr_cnt", 32'(cnt8), 32'd8);
      read8(8'h3C);
      check("ovr_clear", 32'(ovr8), 32'd0);
      check("ovr_cnt_after", 32'(cnt8), 32'd0);

      // Simultaneous read and write
      fill8(8'hFF);
      exp8.push_back(32'hFF);
      r8 = 1'b1; w8 = 1'b1; d8 = 1'b0;
      tick();
      r8 = 1'b0; w8 = 1'b0;
      check("rw_valid", 32'(valid8), 32'd1);
      check("rw_cnt", 32'(cnt8), 32'd1);
      for (int i = 0; i < 7; i++) wr8(1'b0);
      check("rw_full", 32'(full8), 32'd1);
      read8(8'h00);

      // Back-to-back random words, each read overlapping the next word's first bit
      prev = 8'($urandom);
      fill8(prev);
      for (int k = 0; k < 4; k++) begin
         next = 8'($urandom);
         exp8.push_back(32'(prev));
         r8 = 1'b1; w8 = 1'b1; d8 = next[0];
         tick();
         r8 = 1'b0; w8 = 1'b0;
         for (int i = 1; i < 8; i++) wr8(next[i]);
         check("b2b_full", 32'(full8), 32'd1);
         prev = next;
      end
      read8(prev);
      tick();

      // Illegal read mid-word, then reset mid-word
      wr8(1); wr8(1); wr8(0); wr8(1); wr8(0);
      check("ill_cnt", 32'(cnt8), 32'd5);
      r8 = 1'b1;
      tick();
      r8 = 1'b0;
      check("ill_valid", 32'(valid8), 32'd0);
      check("ill_hold", 32'(out8), 32'(prev));
      check("ill_cnt_after", 32'(cnt8), 32'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_cnt", 32'(cnt8), 32'd0);
      wr8(1'b1);
      check("after_rst_cnt", 32'(cnt8), 32'd1);
      for (int i = 1; i < 8; i++) wr8(8'h81 >> i);
      read8(8'h81);

      // Two-word transaction on the 16-bit instance
      w = 16'h3412;
      for (int i = 0; i < 16; i++) begin
         d16 = w[i]; w16 = 1'b1;
         tick();
         w16 = 1'b0;
         if (i == 14) check("w16_full_15", 32'(full16), 32'd0);
      end
      check("w16_full_16", 32'(full16), 32'd1);
      check("w16_cnt", 32'(cnt16), 32'd16);
      exp16.push_back(32'h3412);
      r16 = 1'b1;
      tick();
      r16 = 1'b0;
      check("w16_valid", 32'(valid16), 32'd1);

      tick();
      tick();
      check("pending8", 32'(exp8.size()), 32'd0);
      check("pending16", 32'(exp16.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rx_buffer.md
# rx_buffer

Serial-in/parallel-out receive buffer between the UART receiver's bit stream and the parallel data bus. Bits arrive LSB first, one per write-enable pulse, and are shifted into a WIDTH-bit register. When WIDTH bits have been collected, the buffer raises `full` and holds the word until a parallel read takes it. It flags overrun when bits arrive while a completed word is still unread.

## Interface
- `WORD_SIZE`, default 8: bits per word; must equal the UART data-bit count.
- `NO_OF_WORDS`, default 1: words collected per transaction. WIDTH = WORD_SIZE*NO_OF_WORDS.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_serial_in`  in  1  received bit.
- `data_serial_wr_enable`  in  1  one-cycle strobe; `data_serial_in` is valid this cycle.
- `data_parallel_rd_enable`  in  1  read request from the consumer.
- `data_parallel_out`  out  WIDTH  registered output word; bit 0 is the first bit received.
- `data_parallel_valid`  out  1  one-cycle pulse; `data_parallel_out` was updated this cycle.
- `full`  out  1  WIDTH bits collected and not yet read.
- `overrun`  out  1  sticky flag: a bit arrived while `full` was high.
- `bit_count`  out  COUNTER_WIDTH  bits currently held, 0..WIDTH. COUNTER_WIDTH = floor(log2(WIDTH))+2, the same sizing as the transmit buffer's counter.

## Operation
- State: shift register `shreg`[WIDTH], counter `bit_count`, flag `overrun`, output register, valid register.
- `full` is combinational: `full` = (`bit_count` == WIDTH).
- Priority on each rising edge:
  1. `reset`: `shreg`=0, `bit_count`=0, `data_parallel_out`=0, `data_parallel_valid`=0, `overrun`=0. All other inputs are ignored.
  2. Accepted read (`rd_enable` && `full`): `data_parallel_out` <= `shreg`; `data_parallel_valid` <= 1; `overrun` <= 0. If `wr_enable` is also high this cycle, the bit is kept as the first bit of the next word: `shreg` <= {`data_serial_in`, `shreg`[WIDTH-1:1]} and `bit_count` <= 1. Otherwise `bit_count` <= 0.
  3. Write while not full (`wr_enable` && !`full`): `shreg` <= {`data_serial_in`, `shreg`[WIDTH-1:1]}; `bit_count` <= `bit_count`+1.
  4. Write while full with no read: the bit is discarded, `shreg` and `bit_count` are unchanged, and `overrun` <= 1.
- `data_parallel_valid` is 0 on every edge that does not perform an accepted read.
- A read while not full is ignored: no valid pulse, and `data_parallel_out` holds its value.
- Shifting right with entry at the MSB places the first received bit at bit 0 after WIDTH writes. This is the exact inverse of the transmit buffer, which shifts out from bit 0 first.
- `bit_count` never exceeds WIDTH and never wraps.
- With NO_OF_WORDS>1, word boundaries are not marked. The full WIDTH is one transaction, and word k occupies bits [k*WORD_SIZE +: WORD_SIZE].

## Timing
- Reset values: `data_parallel_out`=0, `data_parallel_valid`=0, `full`=0, `overrun`=0, `bit_count`=0.
- Write latency: `bit_count` reflects a write in the cycle after its enable edge. `full` rises in the cycle after the WIDTH-th write edge.
- Read latency: one cycle. `data_parallel_out` and `data_parallel_valid` update at the read edge, and `full` falls at the same edge.
- Back-to-back: a read and a write on the same edge lose no bit. WIDTH consecutive write cycles plus one read sustain full throughput.
- Reset mid-word discards the partial word; the next write starts at `bit_count`=1.
- `overrun` sets at the first rejected write edge and clears only on an accepted read or reset.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs. Every output must be 0.
- Single word (WIDTH=8): write bits 1,0,1,0,0,1,0,1 (0xA5, LSB first). `full`=1 and `bit_count`=8; a read gives `data_parallel_out`=0xA5 with a 1-cycle valid pulse; `full`=0 next cycle.
- Overrun: fill with 0x3C, then write 2 more bits with no read. `overrun`=1 and `shreg` is unchanged; a read returns 0x3C, `overrun` returns to 0, and `bit_count`=0.
- Simultaneous read and write: fill with 0xFF, then on one edge read and write bit 0. The output is 0xFF and `bit_count`=1. After 7 more 0 bits, a read returns 0x00.
- Illegal read and reset mid-word: read at `bit_count`=5 gives no valid pulse and the output is unchanged. Then reset, write 8 bits of 0x81, and read; the output must be 0x81.
- NO_OF_WORDS=2: write 16 bits forming 0x12 (first) and 0x34. `full` is asserted only after the 16th bit, and a read gives `data_parallel_out`=0x3412.
